// File: rtl/pwm_duty_demod.sv
// PWM duty-cycle demodulator: aligns to a rising edge, counts high cycles per 2**OUT_W frame.
// Define PWM_DEMOD_SYNC_EN to pass pwm_in through a 2-flop synchronizer (+2 cycles latency).
module pwm_duty_demod #(
    parameter int unsigned OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_pwm_in,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [OUT_W-1:0] o_out_duty,
    output logic             o_out_glitch,
    output logic             o_overrun
);

    localparam int unsigned      PERIOD   = 2**OUT_W;
    localparam logic [OUT_W:0]   PERIOD_C = (OUT_W+1)'(PERIOD);
    localparam logic [OUT_W:0]   ONE_C    = (OUT_W+1)'(1);
    localparam logic [OUT_W:0]   LAST_C   = PERIOD_C - ONE_C;
    localparam logic [OUT_W-1:0] DUTY_MAX = '1;

    localparam logic [0:0] ST_ALIGN   = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;

    logic             w_restart;
    logic             w_pwm_s;
    logic             w_rise;
    logic             r_prev;
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [OUT_W:0]   r_win;
    logic [OUT_W:0]   w_win_nxt;
    logic [OUT_W:0]   r_high;
    logic [OUT_W:0]   w_high_nxt;
    logic [1:0]       r_edge;
    logic [1:0]       w_edge_nxt;
    logic             w_smp_vld;
    logic [OUT_W-1:0] w_smp_duty;
    logic             w_smp_glitch;

    assign w_restart = i_rst | i_clear;

`ifdef PWM_DEMOD_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (w_restart) r_sync <= 2'b11;
        else           r_sync <= {r_sync[0], i_pwm_in};
    end

    assign w_pwm_s = r_sync[1];
`else
    assign w_pwm_s = i_pwm_in;
`endif

    // prev resets to 1 so a line already high out of reset is not an edge
    assign w_rise = w_pwm_s & ~r_prev;

    always_comb begin
        w_state_nxt  = r_state;
        w_win_nxt    = r_win + ONE_C;
        w_high_nxt   = r_high + {{OUT_W{1'b0}}, w_pwm_s};
        w_edge_nxt   = (r_edge == 2'd2) ? 2'd2 : r_edge + {1'b0, w_rise};
        w_smp_vld    = 1'b0;
        w_smp_duty   = '0;
        w_smp_glitch = 1'b0;
        case (r_state)
            ST_ALIGN: begin
                w_high_nxt = '0;
                w_edge_nxt = 2'd0;
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                    w_win_nxt   = ONE_C;
                    w_high_nxt  = ONE_C;
                    w_edge_nxt  = 2'd1;
                end else if (r_win == LAST_C) begin
                    w_smp_vld  = 1'b1;
                    w_smp_duty = w_pwm_s ? DUTY_MAX : '0;
                    w_win_nxt  = '0;
                end
            end
            default: begin
                // Full frame accumulated: this cycle is cycle 0 of the next frame
                if (r_win == PERIOD_C) begin
                    w_smp_vld    = 1'b1;
                    w_smp_duty   = (r_high >= PERIOD_C) ? DUTY_MAX : r_high[OUT_W-1:0];
                    w_smp_glitch = (r_edge == 2'd2);
                    w_win_nxt    = ONE_C;
                    w_high_nxt   = {{OUT_W{1'b0}}, w_pwm_s};
                    w_edge_nxt   = {1'b0, w_rise};
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_restart) begin
            r_state <= ST_ALIGN;
            r_prev  <= 1'b1;
            r_win   <= '0;
            r_high  <= '0;
            r_edge  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_pwm_s;
            r_win   <= w_win_nxt;
            r_high  <= w_high_nxt;
            r_edge  <= w_edge_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_restart) begin
            o_out_valid  <= 1'b0;
            o_out_duty   <= '0;
            o_out_glitch <= 1'b0;
            o_overrun    <= 1'b0;
        end else if (w_smp_vld) begin
            o_out_valid  <= 1'b1;
            o_out_duty   <= w_smp_duty;
            o_out_glitch <= w_smp_glitch;
            if (o_out_valid && !i_out_ready) o_overrun <= 1'b1;
        end else if (o_out_valid && i_out_ready) begin
            o_out_valid <= 1'b0;
        end
    end

endmodule
